hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the five-stage core. It drives the synchronous-set (flush to NOP) and enable (advance) inputs of the IF/ID/EX/MEM/WB pipeline registers, and generates the EX-stage forwarding selects. It also runs a multi-cycle-unit (MDU) occupancy FSM and a saturating stall-cycle performance counter. It sits beside the datapath and owns every set and enable of the pipeline flops.

## Interface
Parameters:
- `MDU_LATENCY`, default 8: total cycles an MDU op occupies EX; legal values are ≥ 2.
- `REG_AW`, default 5: register-address width.
- `CNT_W`, default 32: stall-counter width.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rs1_d`, `rs2_d` in REG_AW: source registers of the instruction in ID.
- `rs1_e`, `rs2_e`, `rd_e` in REG_AW: source and destination registers of the instruction in EX.
- `rd_m`, `rd_w` in REG_AW: destination registers in MEM and WB.
- `reg_write_m`, `reg_write_w` in 1: MEM/WB instruction writes `rd`.
- `load_e` in 1: EX instruction is a load.
- `pc_src_e` in 1: EX branch/jump taken.
- `mdu_start_e` in 1: EX instruction is an MDU op.
- `en_f`, `en_d`, `en_e`, `en_m`, `en_w` out 1: pipeline-register enables.
- `set_d`, `set_e`, `set_m` out 1: synchronous flush of the ID/EX/MEM registers to NOP.
- `fwd_a_e`, `fwd_b_e` out 2: operand select. 00 = register file, 01 = WB result, 10 = MEM ALU result.
- `mdu_busy` out 1: FSM in BUSY.
- `mdu_done` out 1: last cycle of an MDU op.
- `stall_cnt` out CNT_W: count of cycles with `en_f`=0.

## Operation
- States: RUN and BUSY. Down-counter `cnt` is `$clog2(MDU_LATENCY)` bits wide.
- Reset (`rst`=1): next state is RUN, `cnt`=0, `stall_cnt`=0. During reset the outputs are:
  - `en_f`..`en_w`=0 and `set_d`=`set_e`=`set_m`=1, so the pipeline fills with NOPs.
  - `mdu_busy`=`mdu_done`=0 and `fwd_*`=00.
- RUN, default: all enables 1, all sets 0.
- RUN, load-use: fires when `load_e`, `rd_e`≠0, and (`rd_e`==`rs1_d` or `rd_e`==`rs2_d`).
  - `en_f`=`en_d`=0, `set_e`=1 (one bubble).
- RUN, `pc_src_e`=1: `set_d`=`set_e`=1, all enables 1.
- `load_e`, `pc_src_e` and `mdu_start_e` describe the same EX instruction and are mutually exclusive by decode. If they are asserted together anyway, priority is MDU > branch > load-use.
- RUN with `mdu_start_e`=1:
  - `en_f`=`en_d`=`en_e`=0, `set_m`=1, `en_w`=1.
  - Load `cnt`=MDU_LATENCY-2 and go to BUSY.
- BUSY, `cnt`≠0: same stall and bubble as the RUN MDU cycle; `cnt`-=1.
  - `load_e`, `pc_src_e` and `mdu_start_e` are ignored, since the same op is still in EX.
- BUSY, `cnt`==0: `mdu_done`=1, all enables 1, sets 0, so the op advances EX→MEM. Go to RUN.
- `mdu_busy`=1 exactly when state==BUSY.
- Forwarding (combinational, same rule for A with `rs1_e` and B with `rs2_e`):
  - 10 if `reg_write_m`, `rd_m`≠0 and `rd_m`==`rs*_e`;
  - else 01 if `reg_write_w`, `rd_w`≠0 and `rd_w`==`rs*_e`;
  - else 00.
  - MEM beats WB when both match.
- `stall_cnt` increments on every non-reset cycle with `en_f`=0 and saturates at all-ones.
- `set_*` overrides `en_*` at the flop. The controller may assert both together; the flop takes the set.

## Timing
- Enables, sets and forwarding are combinational from inputs and state, valid in the same cycle. There are no registered outputs other than `stall_cnt` and `mdu_busy`.
- An MDU op occupies EX for exactly MDU_LATENCY cycles: 1 RUN cycle plus MDU_LATENCY-1 BUSY cycles. `mdu_done` is high on the last of these.
- Load-use costs 1 cycle. A taken branch costs 2 flushed slots.
- An MDU op may immediately follow another MDU op: RUN with `mdu_start_e` on the cycle after `mdu_done`.
- `rst` asserted mid-BUSY: the next cycle is RUN with `cnt`=0, and no `mdu_done` pulse.
- `stall_cnt` updates one cycle after the stalled cycle.

## Test plan
- Reset: hold `rst` for 2 cycles → sets=1 and enables=0 throughout. After release: RUN, `stall_cnt`=0, enables=1.
- Load-use: `load_e`=1, `rd_e`=5, `rs2_d`=5 → `en_f`=`en_d`=0 and `set_e`=1 for one cycle; `stall_cnt` 0→1. Repeat with `rd_e`=0 → no stall.
- Branch: `pc_src_e`=1 → `set_d`=`set_e`=1, `en_f`=1, `stall_cnt` unchanged.
- MDU, MDU_LATENCY=8: `mdu_start_e` pulse →
  - `en_e`=0 for 7 cycles, `mdu_busy` high for 7 cycles;
  - `mdu_done` on cycle 8 with enables=1;
  - `stall_cnt`=7.
  - `pc_src_e` pulsed mid-BUSY is ignored.
- Forwarding: `rd_m`=`rd_w`=`rs1_e`=3, both writes=1 → `fwd_a_e`=10. With `reg_write_m`=0 → 01. With `rd`=0 → 00.
- Reset at BUSY `cnt`=3 → next cycle RUN and enables follow reset rules. `stall_cnt` preset near all-ones (CNT_W=4) saturates at 15.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and hazard_ctrl.
// The datapath side is master (register addresses and decode flags); the controller is slave.
interface hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);
  logic [REG_AW-1:0] rs1_d;
  logic [REG_AW-1:0] rs2_d;
  logic [REG_AW-1:0] rs1_e;
  logic [REG_AW-1:0] rs2_e;
  logic [REG_AW-1:0] rd_e;
  logic [REG_AW-1:0] rd_m;
  logic [REG_AW-1:0] rd_w;
  logic              reg_write_m;
  logic              reg_write_w;
  logic              load_e;
  logic              pc_src_e;
  logic              mdu_start_e;

  logic              en_f;
  logic              en_d;
  logic              en_e;
  logic              en_m;
  logic              en_w;
  logic              set_d;
  logic              set_e;
  logic              set_m;
  logic [1:0]        fwd_a_e;
  logic [1:0]        fwd_b_e;
  logic              mdu_busy;
  logic              mdu_done;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    output reg_write_m, reg_write_w, load_e, pc_src_e, mdu_start_e,
    input  en_f, en_d, en_e, en_m, en_w, set_d, set_e, set_m,
    input  fwd_a_e, fwd_b_e, mdu_busy, mdu_done, stall_cnt
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    input  reg_write_m, reg_write_w, load_e, pc_src_e, mdu_start_e,
    output en_f, en_d, en_e, en_m, en_w, set_d, set_e, set_m,
    output fwd_a_e, fwd_b_e, mdu_busy, mdu_done, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: owns every enable/flush of the IF..WB registers,
// generates EX forwarding selects, tracks MDU occupancy and counts fetch-stall cycles.
module hazard_ctrl #(
  parameter int unsigned MDU_LATENCY = 8,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned CNT_W       = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  localparam int unsigned CW = $clog2(MDU_LATENCY);
  // The RUN start cycle counts as the first occupancy cycle, BUSY covers the rest.
  localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LATENCY - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [CNT_W-1:0] stall_q;

  logic       load_use;
  logic       en_f, en_d, en_e, en_m, en_w;
  logic       set_d, set_e, set_m;
  logic       busy, done;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rd_m,
    input logic [REG_AW-1:0] rd_w,
    input logic              wr_m,
    input logic              wr_w
  );
    if (wr_m && (rd_m != REG_AW'(0)) && (rd_m == rs)) begin
      return 2'b10;
    end else if (wr_w && (rd_w != REG_AW'(0)) && (rd_w == rs)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  // A load into x0 never creates a dependency.
  assign load_use = hz.load_e && (hz.rd_e != REG_AW'(0)) &&
                    ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (hz.mdu_start_e) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_BUSY: begin
        if (cnt_q != CW'(0)) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: enables, flushes and MDU status
  always_comb begin
    en_f  = 1'b1;
    en_d  = 1'b1;
    en_e  = 1'b1;
    en_m  = 1'b1;
    en_w  = 1'b1;
    set_d = 1'b0;
    set_e = 1'b0;
    set_m = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    if (rst) begin
      en_f  = 1'b0;
      en_d  = 1'b0;
      en_e  = 1'b0;
      en_m  = 1'b0;
      en_w  = 1'b0;
      set_d = 1'b1;
      set_e = 1'b1;
      set_m = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hz.mdu_start_e) begin
            // Hold IF/ID/EX, bubble into MEM, let WB drain.
            en_f  = 1'b0;
            en_d  = 1'b0;
            en_e  = 1'b0;
            set_m = 1'b1;
          end else if (hz.pc_src_e) begin
            set_d = 1'b1;
            set_e = 1'b1;
          end else if (load_use) begin
            en_f  = 1'b0;
            en_d  = 1'b0;
            set_e = 1'b1;
          end
        end
        ST_BUSY: begin
          busy = 1'b1;
          if (cnt_q != CW'(0)) begin
            en_f  = 1'b0;
            en_d  = 1'b0;
            en_e  = 1'b0;
            set_m = 1'b1;
          end else begin
            done = 1'b1;
          end
        end
        default: begin
          busy = 1'b0;
        end
      endcase
    end
  end

  // EX operand forwarding, MEM result preferred over WB
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!rst) begin
      fwd_a = fwd_sel(hz.rs1_e, hz.rd_m, hz.rd_w, hz.reg_write_m, hz.reg_write_w);
      fwd_b = fwd_sel(hz.rs2_e, hz.rd_m, hz.rd_w, hz.reg_write_m, hz.reg_write_w);
    end
  end

  // Saturating count of cycles in which fetch was held
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (!en_f && (stall_q != CNT_MAX)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign hz.en_f      = en_f;
  assign hz.en_d      = en_d;
  assign hz.en_e      = en_e;
  assign hz.en_m      = en_m;
  assign hz.en_w      = en_w;
  assign hz.set_d     = set_d;
  assign hz.set_e     = set_e;
  assign hz.set_m     = set_m;
  assign hz.fwd_a_e   = fwd_a;
  assign hz.fwd_b_e   = fwd_b;
  assign hz.mdu_busy  = busy;
  assign hz.mdu_done  = done;
  assign hz.stall_cnt = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a 32-bit and a 4-bit stall-counter instance run in lockstep.
module tb_hazard_ctrl;

  localparam int unsigned L = 8;

  typedef struct packed {
    logic [4:0]  en;
    logic [2:0]  set;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        busy;
    logic        done;
    logic [31:0] stall;
    logic [3:0]  stall4;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rs1_d = '0, rs2_d = '0, rs1_e = '0, rs2_e = '0;
  logic [4:0] rd_e = '0, rd_m = '0, rd_w = '0;
  logic reg_write_m = 1'b0, reg_write_w = 1'b0;
  logic load_e = 1'b0, pc_src_e = 1'b0, mdu_start_e = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  exp_t sb[$];

  int m_left  = 0;
  int m_stall = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) hz ();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  hz4 ();

  assign hz.rs1_d = rs1_d;        assign hz4.rs1_d = rs1_d;
  assign hz.rs2_d = rs2_d;        assign hz4.rs2_d = rs2_d;
  assign hz.rs1_e = rs1_e;        assign hz4.rs1_e = rs1_e;
  assign hz.rs2_e = rs2_e;        assign hz4.rs2_e = rs2_e;
  assign hz.rd_e = rd_e;          assign hz4.rd_e = rd_e;
  assign hz.rd_m = rd_m;          assign hz4.rd_m = rd_m;
  assign hz.rd_w = rd_w;          assign hz4.rd_w = rd_w;
  assign hz.reg_write_m = reg_write_m;  assign hz4.reg_write_m = reg_write_m;
  assign hz.reg_write_w = reg_write_w;  assign hz4.reg_write_w = reg_write_w;
  assign hz.load_e = load_e;      assign hz4.load_e = load_e;
  assign hz.pc_src_e = pc_src_e;  assign hz4.pc_src_e = pc_src_e;
  assign hz.mdu_start_e = mdu_start_e;  assign hz4.mdu_start_e = mdu_start_e;

  hazard_ctrl #(.MDU_LATENCY(L), .REG_AW(5), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  hazard_ctrl #(.MDU_LATENCY(L), .REG_AW(5), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .hz  (hz4)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (reg_write_m && rd_m != 5'd0 && rd_m == rs) return 2'b10;
    if (reg_write_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Expected outputs for the current inputs, from the occupancy model
  function automatic exp_t model_out();
    exp_t e;
    e.en     = 5'b11111;
    e.set    = 3'b000;
    e.fa     = fwd_ref(rs1_e);
    e.fb     = fwd_ref(rs2_e);
    e.busy   = (m_left > 0);
    e.done   = 1'b0;
    e.stall  = 32'(m_stall);
    e.stall4 = (m_stall > 15) ? 4'hF : 4'(m_stall);
    if (rst) begin
      e.en = 5'b00000; e.set = 3'b111; e.fa = 2'b00; e.fb = 2'b00; e.busy = 1'b0;
    end else if (m_left > 1) begin
      e.en = 5'b00011; e.set = 3'b001;
    end else if (m_left == 1) begin
      e.done = 1'b1;
    end else if (mdu_start_e) begin
      e.en = 5'b00011; e.set = 3'b001;
    end else if (pc_src_e) begin
      e.set = 3'b110;
    end else if (load_e && rd_e != 5'd0 && (rd_e == rs1_d || rd_e == rs2_d)) begin
      e.en = 5'b00111; e.set = 3'b010;
    end
    return e;
  endfunction

  task automatic compare_outputs();
    exp_t e;
    check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("en",     {hz.en_f, hz.en_d, hz.en_e, hz.en_m, hz.en_w}, 32'(e.en));
    check("set",    {hz.set_d, hz.set_e, hz.set_m}, 32'(e.set));
    check("fwd_a",  hz.fwd_a_e, 32'(e.fa));
    check("fwd_b",  hz.fwd_b_e, 32'(e.fb));
    check("busy",   hz.mdu_busy, 32'(e.busy));
    check("done",   hz.mdu_done, 32'(e.done));
    check("stall",  hz.stall_cnt, e.stall);
    check("en4",    {hz4.en_f, hz4.en_d, hz4.en_e, hz4.en_m, hz4.en_w}, 32'(e.en));
    check("set4",   {hz4.set_d, hz4.set_e, hz4.set_m}, 32'(e.set));
    check("fwd4",   {hz4.fwd_a_e, hz4.fwd_b_e}, 32'({e.fa, e.fb}));
    check("stat4",  {hz4.mdu_busy, hz4.mdu_done}, 32'({e.busy, e.done}));
    check("stall4", hz4.stall_cnt, 32'(e.stall4));
  endtask

  // One cycle: push expectation, compare at negedge, advance the model at posedge
  task automatic step();
    exp_t e;
    e = model_out();
    sb.push_back(e);
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    if (rst) begin
      m_left  = 0;
      m_stall = 0;
    end else begin
      if (!e.en[4]) m_stall++;
      if (m_left > 0) m_left--;
      else if (mdu_start_e) m_left = L - 1;
    end
    cyc++;
    #1;
  endtask

  task automatic clear_inputs();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0;
    rd_e = '0; rd_m = '0; rd_w = '0;
    reg_write_m = 1'b0; reg_write_w = 1'b0;
    load_e = 1'b0; pc_src_e = 1'b0; mdu_start_e = 1'b0;
  endtask

  initial begin
    // reset held for two cycles
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // load-use stall, then a load to x0 that must not stall
    load_e = 1'b1; rd_e = 5'd5; rs2_d = 5'd5;
    step();
    clear_inputs();
    step();
    load_e = 1'b1; rd_e = 5'd0; rs1_d = 5'd0; rs2_d = 5'd0;
    step();
    clear_inputs();

    // taken branch
    pc_src_e = 1'b1;
    step();
    pc_src_e = 1'b0;
    step();

    // forwarding corners
    rs1_e = 5'd3; rd_m = 5'd3; rd_w = 5'd3; reg_write_m = 1'b1; reg_write_w = 1'b1;
    step();
    reg_write_m = 1'b0;
    step();
    rd_m = 5'd0; rd_w = 5'd0; reg_write_m = 1'b1;
    step();
    clear_inputs();

    // random forwarding / load-use mix
    for (int i = 0; i < 24; i++) begin
      rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
      rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
      rd_e = 5'($urandom_range(0, 3));  rd_m = 5'($urandom_range(0, 3));
      rd_w = 5'($urandom_range(0, 3));
      reg_write_m = 1'($urandom_range(0, 1)); reg_write_w = 1'($urandom_range(0, 1));
      load_e = 1'($urandom_range(0, 1));
      step();
    end
    clear_inputs();

    // single MDU op with a branch and load-use pattern pulsed mid-BUSY
    mdu_start_e = 1'b1;
    step();
    mdu_start_e = 1'b0;
    for (int i = 1; i < int'(L) + 2; i++) begin
      if (i == 3) begin
        pc_src_e = 1'b1; load_e = 1'b1; rd_e = 5'd7; rs1_d = 5'd7;
      end else begin
        pc_src_e = 1'b0; load_e = 1'b0; rd_e = 5'd0; rs1_d = 5'd0;
      end
      step();
    end
    clear_inputs();

    // back-to-back MDU ops, drives the 4-bit counter into saturation
    mdu_start_e = 1'b1;
    for (int i = 0; i < 2 * int'(L); i++) step();
    mdu_start_e = 1'b0;
    step();
    step();

    // all three EX flags together (MDU wins), then reset at BUSY cnt=3
    mdu_start_e = 1'b1; pc_src_e = 1'b1; load_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5;
    step();
    clear_inputs();
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
